// File: rtl/reg_access_arbiter_if.sv
// Register-access bus shared by the requesters and the single-operation AXI-Lite master.
// The arbiter uses the slave view; the requester/AXI side uses the master view.
interface reg_access_arbiter_if #(
  parameter int NUM_REQ    = 4,
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32
);
  logic [NUM_REQ-1:0]              req;
  logic [NUM_REQ-1:0]              req_we;
  logic [NUM_REQ*ADDR_WIDTH-1:0]   req_addr;
  logic [NUM_REQ*DATA_WIDTH-1:0]   req_wdata;
  logic [NUM_REQ*DATA_WIDTH/8-1:0] req_wstrb;
  logic [NUM_REQ-1:0]              ack;
  logic [DATA_WIDTH-1:0]           ack_rdata;
  logic                            ack_err;
  logic                            busy;
  logic                            wr_req;
  logic                            rd_req;
  logic [ADDR_WIDTH-1:0]           addr;
  logic [DATA_WIDTH-1:0]           wdata;
  logic [DATA_WIDTH/8-1:0]         wstrb;
  logic                            op_ack;
  logic [DATA_WIDTH-1:0]           rdata;

  modport slave (
    input  req, req_we, req_addr, req_wdata, req_wstrb, op_ack, rdata,
    output ack, ack_rdata, ack_err, busy, wr_req, rd_req, addr, wdata, wstrb
  );

  modport master (
    output req, req_we, req_addr, req_wdata, req_wstrb, op_ack, rdata,
    input  ack, ack_rdata, ack_err, busy, wr_req, rd_req, addr, wdata, wstrb
  );
endinterface

// File: rtl/reg_access_arbiter.sv
// Round-robin arbiter sharing one pulse-based register-access port among NUM_REQ requesters,
// with a watchdog that error-completes a hung operation and then drains its late acknowledge.
module reg_access_arbiter #(
  parameter int NUM_REQ    = 4,
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32,
  parameter int TIMEOUT    = 1024
) (
  input  logic                 m_axi_aclk,
  input  logic                 m_axi_aresetn,
  reg_access_arbiter_if.slave  bus
);
  localparam int STRB_WIDTH = DATA_WIDTH / 8;
  localparam int IDXW       = $clog2(NUM_REQ);
  localparam int CNTW       = $clog2(TIMEOUT + 1);
  localparam logic [IDXW:0]   NREQ     = (IDXW+1)'(NUM_REQ);
  localparam logic [IDXW-1:0] LAST_IDX = IDXW'(NUM_REQ - 1);
  localparam logic [CNTW-1:0] TO_LAST  = CNTW'(TIMEOUT - 1);

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_FLUSH} state_t;

  state_t                  r_state, w_state_nxt;
  logic [IDXW-1:0]         r_ptr, w_ptr_nxt;
  logic [IDXW-1:0]         r_gnt, w_gnt_nxt;
  logic [CNTW-1:0]         r_cnt, w_cnt_nxt;
  logic [NUM_REQ-1:0]      r_ack, w_ack_nxt;
  logic                    r_ack_err, w_ack_err_nxt;
  logic [DATA_WIDTH-1:0]   r_ack_rdata, w_ack_rdata_nxt;
  logic                    r_busy;
  logic                    r_wr_req, w_wr_nxt;
  logic                    r_rd_req, w_rd_nxt;
  logic [ADDR_WIDTH-1:0]   r_addr, w_addr_nxt;
  logic [DATA_WIDTH-1:0]   r_wdata, w_wdata_nxt;
  logic [STRB_WIDTH-1:0]   r_wstrb, w_wstrb_nxt;

  logic [ADDR_WIDTH-1:0]   w_slot_addr  [NUM_REQ];
  logic [DATA_WIDTH-1:0]   w_slot_wdata [NUM_REQ];
  logic [STRB_WIDTH-1:0]   w_slot_wstrb [NUM_REQ];

  for (genvar g = 0; g < NUM_REQ; g++) begin : g_slot
    assign w_slot_addr[g]  = bus.req_addr[g*ADDR_WIDTH +: ADDR_WIDTH];
    assign w_slot_wdata[g] = bus.req_wdata[g*DATA_WIDTH +: DATA_WIDTH];
    assign w_slot_wstrb[g] = bus.req_wstrb[g*STRB_WIDTH +: STRB_WIDTH];
  end

  // Rotate eligibility so bit 0 is the pointer slot, pick the lowest set bit, then rotate back.
  logic [NUM_REQ-1:0] w_elig, w_rot;
  logic               w_gnt_vld;
  logic [IDXW-1:0]    w_off, w_gnt_idx;
  logic [IDXW:0]      w_sum;

  assign w_elig = bus.req & ~r_ack;
  assign w_rot  = NUM_REQ'({w_elig, w_elig} >> r_ptr);

  always_comb begin
    w_gnt_vld = 1'b0;
    w_off     = '0;
    for (int unsigned k = 0; k < NUM_REQ; k++) begin
      if (!w_gnt_vld && w_rot[k]) begin
        w_gnt_vld = 1'b1;
        w_off     = IDXW'(k);
      end
    end
  end

  assign w_sum     = {1'b0, r_ptr} + {1'b0, w_off};
  assign w_gnt_idx = (w_sum >= NREQ) ? IDXW'(w_sum - NREQ) : w_sum[IDXW-1:0];

  always_comb begin
    w_state_nxt     = r_state;
    w_ptr_nxt       = r_ptr;
    w_gnt_nxt       = r_gnt;
    w_cnt_nxt       = r_cnt;
    w_ack_nxt       = '0;
    w_ack_err_nxt   = r_ack_err;
    w_ack_rdata_nxt = r_ack_rdata;
    w_wr_nxt        = 1'b0;
    w_rd_nxt        = 1'b0;
    w_addr_nxt      = r_addr;
    w_wdata_nxt     = r_wdata;
    w_wstrb_nxt     = r_wstrb;
    unique case (r_state)
      S_IDLE: begin
        if (w_gnt_vld) begin
          w_state_nxt = S_ISSUE;
          w_gnt_nxt   = w_gnt_idx;
          w_ptr_nxt   = (w_gnt_idx == LAST_IDX) ? '0 : w_gnt_idx + 1'b1;
          w_addr_nxt  = w_slot_addr[w_gnt_idx];
          w_wdata_nxt = w_slot_wdata[w_gnt_idx];
          w_wstrb_nxt = w_slot_wstrb[w_gnt_idx];
          w_wr_nxt    = bus.req_we[w_gnt_idx];
          w_rd_nxt    = ~bus.req_we[w_gnt_idx];
        end
      end
      S_ISSUE: begin
        w_cnt_nxt   = '0;
        w_state_nxt = S_WAIT;
      end
      S_WAIT: begin
        if (bus.op_ack) begin
          w_ack_nxt[r_gnt] = 1'b1;
          w_ack_err_nxt    = 1'b0;
          w_ack_rdata_nxt  = bus.rdata;
          w_cnt_nxt        = '0;
          w_state_nxt      = S_IDLE;
        end else if (r_cnt == TO_LAST) begin
          w_ack_nxt[r_gnt] = 1'b1;
          w_ack_err_nxt    = 1'b1;
          w_ack_rdata_nxt  = '0;
          w_cnt_nxt        = '0;
          w_state_nxt      = S_FLUSH;
        end else begin
          w_cnt_nxt = r_cnt + 1'b1;
        end
      end
      S_FLUSH: begin
        if (bus.op_ack || (r_cnt == TO_LAST)) begin
          w_cnt_nxt   = '0;
          w_state_nxt = S_IDLE;
        end else begin
          w_cnt_nxt = r_cnt + 1'b1;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge m_axi_aclk or negedge m_axi_aresetn) begin
    if (!m_axi_aresetn) begin
      r_state     <= S_IDLE;
      r_ptr       <= '0;
      r_gnt       <= '0;
      r_cnt       <= '0;
      r_ack       <= '0;
      r_ack_err   <= 1'b0;
      r_ack_rdata <= '0;
      r_busy      <= 1'b0;
      r_wr_req    <= 1'b0;
      r_rd_req    <= 1'b0;
      r_addr      <= '0;
      r_wdata     <= '0;
      r_wstrb     <= '0;
    end else begin
      r_state     <= w_state_nxt;
      r_ptr       <= w_ptr_nxt;
      r_gnt       <= w_gnt_nxt;
      r_cnt       <= w_cnt_nxt;
      r_ack       <= w_ack_nxt;
      r_ack_err   <= w_ack_err_nxt;
      r_ack_rdata <= w_ack_rdata_nxt;
      r_busy      <= (w_state_nxt != S_IDLE);
      r_wr_req    <= w_wr_nxt;
      r_rd_req    <= w_rd_nxt;
      r_addr      <= w_addr_nxt;
      r_wdata     <= w_wdata_nxt;
      r_wstrb     <= w_wstrb_nxt;
    end
  end

  assign bus.ack       = r_ack;
  assign bus.ack_err   = r_ack_err;
  assign bus.ack_rdata = r_ack_rdata;
  assign bus.busy      = r_busy;
  assign bus.wr_req    = r_wr_req;
  assign bus.rd_req    = r_rd_req;
  assign bus.addr      = r_addr;
  assign bus.wdata     = r_wdata;
  assign bus.wstrb     = r_wstrb;
endmodule

// File: tb/tb_reg_access_arbiter.sv
// Scoreboard bench: a transaction-level round-robin/memory model predicts issues and completions,
// a monitor compares DUT pulses and acks against the queued predictions.
module tb_reg_access_arbiter;
  localparam int N  = 4;
  localparam int AW = 32;
  localparam int DW = 32;
  localparam int SW = DW / 8;
  localparam int TO = 16;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  reg_access_arbiter_if #(.NUM_REQ(N), .ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus ();

  reg_access_arbiter #(.NUM_REQ(N), .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .TIMEOUT(TO)) dut (
    .m_axi_aclk    (clk),
    .m_axi_aresetn (rst_n),
    .bus           (bus)
  );

  typedef struct {
    logic          we;
    logic [AW-1:0] addr;
    logic [DW-1:0] wdata;
    logic [SW-1:0] strb;
    int            d;
    bit            first;
  } iss_t;

  typedef struct {
    int            idx;
    logic          err;
    logic [DW-1:0] rdata;
    int            off;
  } cmp_t;

  iss_t iq[$];
  cmp_t cq[$];
  int   dq[$];
  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;
  int   phase_t0 = 0;
  bit   sb_on = 1'b0;
  int   mptr = 0;
  logic [DW-1:0] smem [logic [AW-1:0]];
  logic [DW-1:0] rmem [logic [AW-1:0]];

  logic          t_we    [N];
  logic [AW-1:0] t_addr  [N];
  logic [DW-1:0] t_wdata [N];
  logic [SW-1:0] t_strb  [N];
  int            t_d     [N];

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  function automatic logic [DW-1:0] merge(input logic [DW-1:0] old, input logic [DW-1:0] d,
                                          input logic [SW-1:0] s);
    logic [DW-1:0] r = old;
    for (int b = 0; b < SW; b++) if (s[b]) r[8*b +: 8] = d[8*b +: 8];
    return r;
  endfunction

  task automatic set_slot(input int i, input logic we, input logic [AW-1:0] a,
                          input logic [DW-1:0] w, input logic [SW-1:0] s, input int d);
    t_we[i] = we; t_addr[i] = a; t_wdata[i] = w; t_strb[i] = s; t_d[i] = d;
  endtask

  // Response delay: 1..TO completes normally, 0 never acks, TO+1..2*TO acks during the drain.
  function automatic int rand_d();
    int r = int'($urandom_range(0, 19));
    if (r == 19) return 0;
    if (r == 18) return TO + 1 + int'($urandom_range(0, TO - 1));
    if (r == 17) return TO;
    return 1 + (r % 6);
  endfunction

  task automatic run_phase(input logic [N-1:0] set);
    int   order[$];
    int   got = 0;
    bit   done = 1'b0;
    bit   normal;
    logic [N-1:0] a;
    logic b;
    iss_t e;
    cmp_t c;
    for (int k = 0; k < N; k++) if (set[(mptr + k) % N]) order.push_back((mptr + k) % N);
    foreach (order[j]) begin
      int i = order[j];
      e.we = t_we[i]; e.addr = t_addr[i]; e.wdata = t_wdata[i]; e.strb = t_strb[i];
      e.d = t_d[i]; e.first = (j == 0);
      iq.push_back(e);
      dq.push_back(t_d[i]);
      normal = (t_d[i] >= 1) && (t_d[i] <= TO);
      if (t_we[i])
        rmem[t_addr[i]] = merge(rmem.exists(t_addr[i]) ? rmem[t_addr[i]] : '0, t_wdata[i], t_strb[i]);
      c.idx   = i;
      c.err   = !normal;
      c.rdata = normal ? (rmem.exists(t_addr[i]) ? rmem[t_addr[i]] : '0) : '0;
      c.off   = normal ? t_d[i] + 1 : TO + 1;
      cq.push_back(c);
    end
    if (order.size() > 0) mptr = (order[order.size()-1] + 1) % N;
    @(posedge clk); #1;
    for (int i = 0; i < N; i++) begin
      if (set[i]) begin
        bus.req_we[i]             = t_we[i];
        bus.req_addr[i*AW +: AW]  = t_addr[i];
        bus.req_wdata[i*DW +: DW] = t_wdata[i];
        bus.req_wstrb[i*SW +: SW] = t_strb[i];
      end
    end
    bus.req  = bus.req | set;
    phase_t0 = cyc;
    for (int n = 0; n < 4000 && !done; n++) begin
      @(negedge clk);
      a = bus.ack;
      b = bus.busy;
      @(posedge clk); #1;
      bus.req = bus.req & ~a;
      if (a != '0) got++;
      if (got == order.size() && !b) done = 1'b1;
    end
    if (!done) begin
      checks++; errors++;
      $display("FAIL phase_timeout: got %0d acks expected %0d", got, order.size());
    end
  endtask

  initial begin : monitor
    iss_t e;
    cmp_t c;
    int   last_pulse = 0;
    int   last_d = 1;
    int   exp_cyc;
    forever begin
      @(negedge clk);
      if (sb_on) begin
        if (bus.wr_req || bus.rd_req) begin
          chk("pulse_excl", 128'(bus.wr_req & bus.rd_req), 128'(0));
          if (iq.size() == 0) begin
            checks++; errors++;
            $display("FAIL issue_unexpected: got addr %0h expected no issue", bus.addr);
          end else begin
            e = iq.pop_front();
            chk("issue", 128'({bus.wr_req, bus.addr, bus.wdata, bus.wstrb}),
                128'({e.we, e.addr, e.wdata, e.strb}));
            exp_cyc = e.first ? phase_t0 + 1
                    : last_pulse + ((last_d == 0) ? 2*TO + 2 : last_d + 2);
            chk("issue_cycle", 128'(cyc), 128'(exp_cyc));
            last_pulse = cyc;
            last_d     = e.d;
          end
        end
        if (bus.ack != '0) begin
          if (cq.size() == 0) begin
            checks++; errors++;
            $display("FAIL ack_unexpected: got ack %b expected none", bus.ack);
          end else begin
            c = cq.pop_front();
            chk("ack", 128'({bus.ack, bus.ack_err, bus.ack_rdata}),
                128'({N'(1 << c.idx), c.err, c.rdata}));
            chk("ack_cycle", 128'(cyc), 128'(last_pulse + c.off));
          end
        end
      end
    end
  end

  initial begin : responder
    int            d;
    logic [AW-1:0] a;
    logic [DW-1:0] resp;
    forever begin
      @(negedge clk);
      if (rst_n && (bus.wr_req || bus.rd_req)) begin
        d = (dq.size() > 0) ? dq.pop_front() : 0;
        a = bus.addr;
        if (bus.wr_req) smem[a] = merge(smem.exists(a) ? smem[a] : '0, bus.wdata, bus.wstrb);
        resp = smem.exists(a) ? smem[a] : '0;
        if (d > 0) begin
          repeat (d) @(posedge clk);
          #1; bus.op_ack = 1'b1; bus.rdata = resp;
          @(posedge clk);
          #1; bus.op_ack = 1'b0; bus.rdata = $urandom;
        end
      end
    end
  end

  initial begin : driver
    logic [N-1:0] set;
    logic [N-1:0] seen;
    bit           pulsed;
    bus.req = '0; bus.req_we = '0; bus.req_addr = '0; bus.req_wdata = '0; bus.req_wstrb = '0;
    bus.op_ack = 1'b0; bus.rdata = '0;

    repeat (3) @(posedge clk);
    #1;
    chk("reset_ctrl", 128'({bus.ack, bus.ack_err, bus.busy, bus.wr_req, bus.rd_req}), 128'(0));
    chk("reset_data", 128'({bus.ack_rdata, bus.addr, bus.wdata, bus.wstrb}), 128'(0));
    @(negedge clk);
    rst_n = 1'b1;
    sb_on = 1'b1;

    set_slot(0, 1'b1, 32'h10, 32'hA5A5_0001, 4'hF, 5);           run_phase(4'b0001);
    set_slot(1, 1'b1, 32'h20, 32'h1234_5678, 4'hF, 3);           run_phase(4'b0010);
    set_slot(2, 1'b0, 32'h20, 32'hDEAD_BEEF, 4'h0, 4);           run_phase(4'b0100);
    set_slot(3, 1'b1, 32'h10, 32'h0000_BB00, 4'h2, TO);          run_phase(4'b1000);
    for (int i = 0; i < N; i++)
      set_slot(i, 1'($urandom_range(0, 1)), 32'(i*4), $urandom, 4'($urandom_range(0, 15)), 2 + i);
    run_phase(4'b1111);
    set_slot(1, 1'b0, 32'h10, 32'h0, 4'h0, 2);
    set_slot(3, 1'b0, 32'h20, 32'h0, 4'h0, 1);
    run_phase(4'b1010);
    run_phase(4'b0010);
    set_slot(2, 1'b0, 32'h10, 32'h0, 4'h0, 0);
    set_slot(0, 1'b1, 32'h18, 32'hCAFE_F00D, 4'h5, 2);
    run_phase(4'b0101);
    set_slot(1, 1'b1, 32'h1C, 32'h7777_1111, 4'hF, TO + 6);
    set_slot(3, 1'b0, 32'h1C, 32'h0, 4'h0, 1);
    run_phase(4'b1010);

    for (int p = 0; p < 12; p++) begin
      set = N'($urandom_range(1, (1 << N) - 1));
      for (int i = 0; i < N; i++)
        set_slot(i, 1'($urandom_range(0, 1)), 32'($urandom_range(0, 7) * 4), $urandom,
                 4'($urandom_range(0, 15)), rand_d());
      run_phase(set);
    end

    // Asynchronous reset while an operation is waiting for its acknowledge.
    sb_on = 1'b0;
    dq.push_back(0);
    @(posedge clk); #1;
    bus.req_we[1] = 1'b0;
    bus.req_addr[1*AW +: AW]  = 32'h44;
    bus.req_wdata[1*DW +: DW] = 32'h5555_AAAA;
    bus.req_wstrb[1*SW +: SW] = 4'h3;
    bus.req[1] = 1'b1;
    pulsed = 1'b0;
    for (int n = 0; n < 20 && !pulsed; n++) begin
      @(negedge clk);
      if (bus.rd_req) pulsed = 1'b1;
    end
    chk("rst_test_issue", 128'(pulsed), 128'(1));
    repeat (3) @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("async_rst_ctrl", 128'({bus.ack, bus.ack_err, bus.busy, bus.wr_req, bus.rd_req}), 128'(0));
    chk("async_rst_data", 128'({bus.ack_rdata, bus.addr, bus.wdata, bus.wstrb}), 128'(0));
    bus.req = '0;
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1 bus.op_ack = 1'b1;
    @(posedge clk); #1 bus.op_ack = 1'b0;
    seen = '0;
    repeat (5) begin
      @(negedge clk);
      seen = seen | bus.ack;
    end
    chk("stray_ack", 128'(seen), 128'(0));

    sb_on = 1'b1;
    mptr  = 0;
    set_slot(0, 1'b0, 32'h20, 32'h0, 4'h0, 3);
    set_slot(3, 1'b1, 32'h24, 32'h0BAD_CAFE, 4'hC, 2);
    run_phase(4'b1001);

    repeat (4) @(posedge clk);
    chk("issue_queue_empty", 128'(iq.size()), 128'(0));
    chk("ack_queue_empty", 128'(cq.size()), 128'(0));
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
